// File: rtl/divu_seq_if.sv
// Handshake and operand/result bundle for the sequential unsigned divider.
interface divu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output start, a, b,
        input  busy, done, q, r
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r
    );
endinterface

// File: rtl/divu_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Quotient drives LO, remainder drives HI.
module divu_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    divu_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   pr;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;

    logic [WIDTH:0]   pr_sh;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH:0]   pr_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // Guard bit in pr keeps the compare correct for divisors with MSB set.
    always_comb begin
        pr_sh   = {pr[WIDTH-1:0], dvd[WIDTH-1]};
        diff    = pr_sh - {1'b0, dvs};
        qbit    = ~diff[WIDTH];
        pr_nxt  = qbit ? diff : pr_sh;
        quo_nxt = {quo[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            dvd    <= '0;
            dvs    <= '0;
            quo    <= '0;
            pr     <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dvd    <= bus.a;
                        dvs    <= bus.b;
                        quo    <= '0;
                        pr     <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    pr  <= pr_nxt;
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        q_r    <= quo_nxt;
                        r_r    <= pr_nxt[WIDTH-1:0];
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.q    = q_r;
    assign bus.r    = r_r;
endmodule

// File: tb/tb_divu_seq.sv
// Directed and regression bench for divu_seq.
module tb_divu_seq;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    divu_seq_if #(.WIDTH(W)) bus ();

    divu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, return cycles spent busy after the start edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat = 0;
        while (bus.busy && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.q, bus.r} !== {2'b00, 64'h0}) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h want 0",
                     bus.busy, bus.done, bus.q, bus.r);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int lat;
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: busy=%b done=%b want 1 0",
                     bus.busy, bus.done);
        end
        lat = 0;
        while (bus.busy && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 32 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: lat=%0d done=%b want 32 1",
                     lat, bus.done);
        end
        checks++;
        if (bus.q !== 32'd14 || bus.r !== 32'd2) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d want 14 2",
                     bus.q, bus.r);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.q !== 32'd14 || bus.r !== 32'd2) begin
            errors++;
            $display("FAIL basic_pulse: done=%b q=%0d r=%0d want 0 14 2",
                     bus.done, bus.q, bus.r);
        end
    endtask

    task automatic test_edges();
        int lat;
        run_op(32'hFFFF_FFFF, 32'd1, lat);
        checks++;
        if (bus.q !== 32'hFFFF_FFFF || bus.r !== 32'h0 || lat !== 32) begin
            errors++;
            $display("FAIL max_by_one: q=%h r=%h lat=%0d want ffffffff 0 32",
                     bus.q, bus.r, lat);
        end
        tick();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if (bus.q !== 32'h0 || bus.r !== 32'h8000_0000) begin
            errors++;
            $display("FAIL guard_bit: q=%h r=%h want 0 80000000",
                     bus.q, bus.r);
        end
        tick();
        run_op(32'hFFFF_FFFE, 32'h8000_0000, lat);
        checks++;
        if (bus.q !== 32'h1 || bus.r !== 32'h7FFF_FFFE) begin
            errors++;
            $display("FAIL big_divisor: q=%h r=%h want 1 7ffffffe",
                     bus.q, bus.r);
        end
        tick();
        run_op(32'd3, 32'd10, lat);
        checks++;
        if (bus.q !== 32'h0 || bus.r !== 32'd3) begin
            errors++;
            $display("FAIL small_dividend: q=%h r=%h want 0 3", bus.q, bus.r);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat;
        int dn;
        run_op(32'd5, 32'd0, lat);
        checks++;
        if (bus.q !== 32'hFFFF_FFFF || bus.r !== 32'd5 || lat !== 32) begin
            errors++;
            $display("FAIL div_zero: q=%h r=%h lat=%0d want ffffffff 5 32",
                     bus.q, bus.r, lat);
        end
        dn = bus.done ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done) dn++;
        end
        checks++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL div_zero_pulse: done_count=%0d want 1", dn);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        lat = 10;
        while (bus.busy && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (bus.q !== 32'd14 || bus.r !== 32'd2 || lat !== 32) begin
            errors++;
            $display("FAIL ignore_busy: q=%0d r=%0d lat=%0d want 14 2 32",
                     bus.q, bus.r, lat);
        end
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_start: busy=%b done=%b want 1 0",
                     bus.busy, bus.done);
        end
        lat = 0;
        while (bus.busy && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (bus.q !== 32'd3 || bus.r !== 32'd0 || lat !== 32) begin
            errors++;
            $display("FAIL accept_in_done: q=%0d r=%0d lat=%0d want 3 0 32",
                     bus.q, bus.r, lat);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dn;
        bus.start = 1'b1;
        bus.a     = 32'd1000;
        bus.b     = 32'd10;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.q, bus.r} !== {2'b00, 64'h0}) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h want 0",
                     bus.busy, bus.done, bus.q, bus.r);
        end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL reset_abandon: active_cycles=%0d want 0", dn);
        end
    endtask

    task automatic test_random();
        int               lat;
        int               dn;
        int               n;
        logic [W-1:0]     av;
        logic [W-1:0]     bv;
        logic [W-1:0]     eq;
        logic [W-1:0]     er;
        n  = 1000;
        dn = 0;
        for (int i = 0; i < n; i++) begin
            av = $urandom;
            bv = $urandom;
            if (i % 50 == 0) bv = '0;
            else if (i % 50 == 1) bv = 32'd1;
            else if (i % 5 == 2) bv = W'($urandom_range(2, 300));
            else if (i % 5 == 3) av = W'($urandom_range(0, 1000));
            eq = (bv == 0) ? '1 : av / bv;
            er = (bv == 0) ? av : av % bv;
            run_op(av, bv, lat);
            if (bus.done) dn++;
            checks++;
            if (bus.q !== eq || bus.r !== er || lat !== 32) begin
                errors++;
                $display("FAIL random %0d: a=%h b=%h q=%h r=%h lat=%0d want %h %h 32",
                         i, av, bv, bus.q, bus.r, lat, eq, er);
            end
        end
        tick();
        checks++;
        if (dn !== n || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL random_done_count: got=%0d want %0d", dn, n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
